// File: rtl/i2s_tx_serializer.sv
// I2S master transmitter: MCLK/SCLK/LRCLK generation, one-deep sample hold, MSB-first serialization.
// Define I2S_UNDRN_CNT_EN to add the saturating undrn_cnt[7:0] underrun event counter.
module i2s_tx_serializer #(
    parameter int IN_W = 16
) (
    input  logic                   clk,
    input  logic                   RST,
    input  logic signed [IN_W-1:0] lft_in,
    input  logic signed [IN_W-1:0] rht_in,
    input  logic                   wrt,
    output logic                   rdy,
    output logic                   frm_strt,
    output logic                   MCLK,
    output logic                   SCLK,
    output logic                   LRCLK,
    output logic                   SDin,
    output logic                   undrn
`ifdef I2S_UNDRN_CNT_EN
    ,
    output logic [7:0]             undrn_cnt
`endif
);

    logic [10:0]     cnt;
    logic [IN_W-1:0] hold_l, hold_r;
    logic [IN_W-1:0] act_l, act_r;
    logic [IN_W-1:0] act_l_next;
    logic            full;
    logic            armed;
    logic [31:0]     shreg;
    logic            frame_end;
    logic            right_start;
    logic            slot_end;

    // Slot 0 stays 0 for the I2S one-bit delay; the sample follows MSB-first.
    function automatic logic [31:0] slot_word(input logic [IN_W-1:0] s);
        logic [31:0] w;
        w = '0;
        w[30 -: IN_W] = s;
        return w;
    endfunction

    assign frame_end   = (cnt == 11'd2047);
    assign right_start = (cnt == 11'd1023);
    assign slot_end    = (cnt[4:0] == 5'd31);
    assign act_l_next  = (frame_end && full) ? hold_l : act_l;

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            cnt      <= '0;
            hold_l   <= '0;
            hold_r   <= '0;
            act_l    <= '0;
            act_r    <= '0;
            full     <= 1'b0;
            armed    <= 1'b0;
            frm_strt <= 1'b0;
            undrn    <= 1'b0;
            shreg    <= '0;
        end else begin
            cnt      <= cnt + 11'd1;
            frm_strt <= 1'b0;

            if (wrt) begin
                hold_l <= lft_in;
                hold_r <= rht_in;
            end

            // A write landing on the transfer edge refills hold, so full stays set.
            if (wrt)
                full <= 1'b1;
            else if (frame_end)
                full <= 1'b0;

            if (frame_end) begin
                if (full) begin
                    act_l    <= hold_l;
                    act_r    <= hold_r;
                    frm_strt <= 1'b1;
                    armed    <= 1'b1;
                end else if (armed) begin
                    undrn <= 1'b1;
                end
            end

            if (frame_end)
                shreg <= slot_word(act_l_next);
            else if (right_start)
                shreg <= slot_word(act_r);
            else if (slot_end)
                shreg <= {shreg[30:0], 1'b0};
        end
    end

`ifdef I2S_UNDRN_CNT_EN
    always_ff @(posedge clk or posedge RST) begin
        if (RST)
            undrn_cnt <= '0;
        else if (frame_end && !full && armed && (undrn_cnt != 8'hFF))
            undrn_cnt <= undrn_cnt + 8'd1;
    end
`endif

    // Clock outputs are counter flop bits, so they cannot glitch.
    assign MCLK  = cnt[1];
    assign SCLK  = cnt[4];
    assign LRCLK = cnt[10];
    assign SDin  = shreg[31];
    assign rdy   = ~full;

endmodule
